// File: rtl/izh_pkg.sv
// Shared constants and FSM encoding for the Izhikevich core scheduler slice.
// Resting values are whole numbers and are scaled into fixed point where they are used.
package izh_pkg;

    localparam int V_WIDTH_DEF  = 20;
    localparam int FR_WIDTH_DEF = 11;
    localparam int V_RESET      = -65;
    localparam int W_RESET      = -12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_SPIKE = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

    function automatic int to_fixed(input int whole, input int fr);
        return whole * (1 << fr);
    endfunction

endpackage

// File: rtl/izh_state_regfile.sv
// Per-neuron v/w state: one write port plus two combinational read ports (datapath, debug).
// Async reset loads the resting values; a write lands at the edge and reads see it the next cycle.
module izh_state_regfile
    import izh_pkg::*;
#(
    parameter  int N_NEURONS = 16,
    parameter  int V_WIDTH   = V_WIDTH_DEF,
    parameter  int FR_WIDTH  = FR_WIDTH_DEF,
    localparam int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_we,
    input  logic [IDX_W-1:0]          i_wr_idx,
    input  logic signed [V_WIDTH-1:0] i_wr_v,
    input  logic signed [V_WIDTH-1:0] i_wr_w,
    input  logic [IDX_W-1:0]          i_rd_idx,
    input  logic [IDX_W-1:0]          i_dbg_idx,
    output logic signed [V_WIDTH-1:0] o_rd_v,
    output logic signed [V_WIDTH-1:0] o_rd_w,
    output logic signed [V_WIDTH-1:0] o_dbg_v
);

    localparam logic signed [V_WIDTH-1:0] V_INIT = V_WIDTH'(to_fixed(V_RESET, FR_WIDTH));
    localparam logic signed [V_WIDTH-1:0] W_INIT = V_WIDTH'(to_fixed(W_RESET, FR_WIDTH));

    logic signed [V_WIDTH-1:0] r_v [N_NEURONS];
    logic signed [V_WIDTH-1:0] r_w [N_NEURONS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_v[i] <= V_INIT;
                r_w[i] <= W_INIT;
            end
        end else if (i_we) begin
            r_v[i_wr_idx] <= i_wr_v;
            r_w[i_wr_idx] <= i_wr_w;
        end
    end

    assign o_rd_v  = r_v[i_rd_idx];
    assign o_rd_w  = r_w[i_rd_idx];
    assign o_dbg_v = r_v[i_dbg_idx];

endmodule

// File: rtl/izh_core_scheduler.sv
// Sweeps one shared Izhikevich integrator over all neurons per tick: FETCH/EXEC per neuron, 2N+1 cycles
// from tick_start to tick_done; each spike adds one cycle and stalls until spk_ready accepts it.
module izh_core_scheduler
    import izh_pkg::*;
#(
    parameter  int N_NEURONS = 16,
    parameter  int V_WIDTH   = V_WIDTH_DEF,
    parameter  int FR_WIDTH  = FR_WIDTH_DEF,
    localparam int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick_start,
    output logic                      busy,
    output logic                      tick_done,
    output logic [IDX_W-1:0]          syn_addr,
    input  logic signed [V_WIDTH-1:0] syn_data,
    output logic signed [V_WIDTH-1:0] dp_I,
    output logic signed [V_WIDTH-1:0] dp_v_old,
    output logic signed [V_WIDTH-1:0] dp_w_old,
    input  logic signed [V_WIDTH-1:0] dp_v_new,
    input  logic signed [V_WIDTH-1:0] dp_w_new,
    input  logic                      dp_fire,
    output logic                      spk_valid,
    output logic [IDX_W-1:0]          spk_id,
    input  logic                      spk_ready,
    output logic [IDX_W:0]            spike_count,
    input  logic [IDX_W-1:0]          dbg_sel,
    output logic signed [V_WIDTH-1:0] dbg_v
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W:0]   CNT_MAX  = (IDX_W + 1)'(N_NEURONS);

    sched_state_t     r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy;
    logic             r_tick_done;
    logic             r_spk_valid;
    logic [IDX_W-1:0] r_spk_id;
    logic [IDX_W:0]   r_spike_count;

    logic                      w_exec;
    logic                      w_advance;
    logic signed [V_WIDTH-1:0] w_rd_v;
    logic signed [V_WIDTH-1:0] w_rd_w;

    assign w_exec    = (r_state == ST_EXEC);
    // A non-firing EXEC and an accepted spike both move on to the next neuron.
    assign w_advance = (w_exec && !dp_fire) || ((r_state == ST_SPIKE) && spk_ready);

    izh_state_regfile #(
        .N_NEURONS (N_NEURONS),
        .V_WIDTH   (V_WIDTH),
        .FR_WIDTH  (FR_WIDTH)
    ) u_state (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_exec),
        .i_wr_idx  (r_idx),
        .i_wr_v    (dp_v_new),
        .i_wr_w    (dp_w_new),
        .i_rd_idx  (r_idx),
        .i_dbg_idx (dbg_sel),
        .o_rd_v    (w_rd_v),
        .o_rd_w    (w_rd_w),
        .o_dbg_v   (dbg_v)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_busy        <= 1'b0;
            r_tick_done   <= 1'b0;
            r_spk_valid   <= 1'b0;
            r_spk_id      <= '0;
            r_spike_count <= '0;
        end else begin
            r_tick_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tick_start) begin
                        r_state       <= ST_FETCH;
                        r_idx         <= '0;
                        r_spike_count <= '0;
                        r_busy        <= 1'b1;
                    end
                end
                ST_FETCH: r_state <= ST_EXEC;
                ST_EXEC: begin
                    if (dp_fire) begin
                        r_state     <= ST_SPIKE;
                        r_spk_valid <= 1'b1;
                        r_spk_id    <= r_idx;
                        if (r_spike_count != CNT_MAX) begin
                            r_spike_count <= r_spike_count + 1'b1;
                        end
                    end
                end
                ST_SPIKE: begin
                    if (spk_ready) begin
                        r_spk_valid <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_advance) begin
                if (r_idx == LAST_IDX) begin
                    r_state     <= ST_DONE;
                    r_tick_done <= 1'b1;
                end else begin
                    r_idx   <= r_idx + 1'b1;
                    r_state <= ST_FETCH;
                end
            end
        end
    end

    // syn_addr is stable through FETCH and EXEC, so both sync- and async-read stores work.
    assign syn_addr    = r_idx;
    assign busy        = r_busy;
    assign tick_done   = r_tick_done;
    assign spk_valid   = r_spk_valid;
    assign spk_id      = r_spk_id;
    assign spike_count = r_spike_count;
    assign dp_I        = w_exec ? syn_data : '0;
    assign dp_v_old    = w_rd_v;
    assign dp_w_old    = w_rd_w;

endmodule

// File: tb/tb_izh_core_scheduler.sv
// Scoreboard bench: a toy integrator plus per-neuron model predict spikes, sweep latency and v state.
module tb_izh_core_scheduler;
    import izh_pkg::*;

    localparam int N      = 16;
    localparam int VW     = 20;
    localparam int FR     = 11;
    localparam int IW     = $clog2(N);
    localparam int ONE    = 1 << FR;
    localparam int V_INIT = V_RESET * ONE;
    localparam int W_INIT = W_RESET * ONE;
    localparam int V_PEAK = 30 * ONE;

    typedef struct {
        int start;
        int lat;
        int cnt;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset, tick_start, busy, tick_done;
    logic [IW-1:0]        syn_addr, spk_id, dbg_sel;
    logic signed [VW-1:0] syn_data, dp_I, dp_v_old, dp_w_old, dp_v_new, dp_w_new, dbg_v;
    logic                 dp_fire, spk_valid, spk_ready;
    logic [IW:0]          spike_count;

    logic signed [VW-1:0] syn_mem [N];
    int   mv [N];
    int   mw [N];
    exp_t done_q [$];
    int   spk_q [$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   stall_mode = 1'b0;
    int   stall_cnt = 0;
    logic prev_stall = 1'b0;
    int   prev_id = 0;
    int   raw;
    int   s0;

    izh_core_scheduler #(.N_NEURONS(N), .V_WIDTH(VW), .FR_WIDTH(FR)) dut (
        .clk(clk), .reset(reset), .tick_start(tick_start), .busy(busy), .tick_done(tick_done),
        .syn_addr(syn_addr), .syn_data(syn_data), .dp_I(dp_I), .dp_v_old(dp_v_old),
        .dp_w_old(dp_w_old), .dp_v_new(dp_v_new), .dp_w_new(dp_w_new), .dp_fire(dp_fire),
        .spk_valid(spk_valid), .spk_id(spk_id), .spk_ready(spk_ready),
        .spike_count(spike_count), .dbg_sel(dbg_sel), .dbg_v(dbg_v)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Toy integrator: v grows by I + 1.0 + (w drift); fires at +30, resets v and bumps w by 8.0.
    function automatic int integ_raw(input int i_cur, input int v, input int w);
        return v + i_cur + ONE + (w - W_INIT);
    endfunction

    always_comb begin
        raw      = integ_raw(int'(dp_I), int'(dp_v_old), int'(dp_w_old));
        dp_fire  = (raw >= V_PEAK);
        dp_v_new = dp_fire ? VW'(V_INIT) : VW'(raw);
        dp_w_new = dp_fire ? VW'(int'(dp_w_old) + 8 * ONE) : VW'(int'(dp_w_old) + 1);
    end

    assign syn_data = syn_mem[syn_addr];

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic run_tick(input bit stall);
        int   nsp = 0;
        int   r;
        exp_t x;
        for (int i = 0; i < N; i++) begin
            r = integ_raw(int'(syn_mem[i]), mv[i], mw[i]);
            if (r >= V_PEAK) begin
                mv[i] = V_INIT;
                mw[i] += 8 * ONE;
                spk_q.push_back(i);
                nsp++;
            end else begin
                mv[i] = r;
                mw[i] += 1;
            end
        end
        stall_mode = stall;
        @(negedge clk);
        tick_start = 1'b1;
        @(negedge clk);
        tick_start = 1'b0;
        x.start = cyc;
        x.lat   = 2 * N + 1 + nsp * (stall ? 6 : 1);
        x.cnt   = nsp;
        done_q.push_back(x);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("tick_done_timeout_pending", done_q.size(), 0);
        if (done_q.size() != 0) begin
            done_q.delete();
            spk_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_dbg(input string tag);
        for (int i = 0; i < N; i++) begin
            dbg_sel = IW'(i);
            #1;
            chk($sformatf("%s[%0d]", tag, i), int'(dbg_v), mv[i]);
        end
    endtask

    // Downstream router model: optionally refuses each spike for 5 cycles.
    initial begin
        spk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (stall_mode && spk_valid && stall_cnt < 5) begin
                spk_ready = 1'b0;
                stall_cnt++;
            end else begin
                spk_ready = 1'b1;
                if (!spk_valid) stall_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_spk_valid_held", int'(spk_valid), 1);
                chk("stall_spk_id_held", int'(spk_id), prev_id);
                chk("stall_busy", int'(busy), 1);
            end
            if (spk_valid && spk_ready) begin
                chk("spike_expected", int'(spk_q.size() > 0), 1);
                if (spk_q.size() > 0) chk("spk_id", int'(spk_id), spk_q.pop_front());
            end
            if (tick_done) begin
                chk("tick_done_expected", int'(done_q.size() > 0), 1);
                if (done_q.size() > 0) begin
                    mon_e = done_q.pop_front();
                    chk("tick_done_cycle", cyc - mon_e.start + 1, mon_e.lat);
                    chk("spike_count", int'(spike_count), mon_e.cnt);
                end
            end
            prev_stall <= spk_valid && !spk_ready;
            prev_id    <= int'(spk_id);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        tick_start = 1'b0;
        dbg_sel    = '0;
        for (int i = 0; i < N; i++) begin
            syn_mem[i] = '0;
            mv[i]      = V_INIT;
            mw[i]      = W_INIT;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("reset_busy", int'(busy), 0);
        chk("reset_spk_valid", int'(spk_valid), 0);
        chk("reset_tick_done", int'(tick_done), 0);
        chk("reset_spike_count", int'(spike_count), 0);
        chk("reset_syn_addr", int'(syn_addr), 0);
        chk("reset_spk_id", int'(spk_id), 0);
        check_dbg("reset_dbg_v");

        // Spike-free sweep
        run_tick(1'b0);
        wait_done();
        check_dbg("zero_input_v");

        // Extra tick_start pulses in cycle 4 and in the DONE cycle (33)
        run_tick(1'b0);
        s0 = cyc;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            tick_start = ((cyc - s0) == 3) || ((cyc - s0) == 32);
        end
        tick_start = 1'b0;
        chk("extra_start_busy", int'(busy), 0);
        chk("extra_start_pending", done_q.size(), 0);
        check_dbg("extra_start_v");

        // Only neuron 3 driven: it alone fires after several ticks
        syn_mem[3] = VW'(20 * ONE);
        repeat (6) begin
            run_tick(1'b0);
            wait_done();
        end
        check_dbg("drive3_v");

        // Spikes held off by the router for 5 cycles each
        repeat (4) begin
            run_tick(1'b1);
            wait_done();
        end
        check_dbg("stall_v");

        // Every neuron fires in one sweep: spike_count reaches N_NEURONS
        for (int i = 0; i < N; i++) syn_mem[i] = VW'(100 * ONE);
        run_tick(1'b0);
        wait_done();
        check_dbg("all_fire_v");

        // Reset in the middle of a sweep
        for (int i = 0; i < N; i++) syn_mem[i] = '0;
        run_tick(1'b0);
        for (int k = 0; k < 100 && !(busy && syn_addr == IW'(7)); k++) @(negedge clk);
        chk("abort_at_idx7", int'(syn_addr), 7);
        reset = 1'b1;
        #1;
        done_q.delete();
        spk_q.delete();
        for (int i = 0; i < N; i++) begin
            mv[i] = V_INIT;
            mw[i] = W_INIT;
        end
        chk("abort_busy", int'(busy), 0);
        chk("abort_spk_valid", int'(spk_valid), 0);
        chk("abort_syn_addr", int'(syn_addr), 0);
        check_dbg("abort_dbg_v");
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_abort_busy", int'(busy), 0);
        run_tick(1'b0);
        wait_done();
        check_dbg("post_abort_v");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
